// File: rtl/oct_acq_pkg.sv
// Shared definitions for the OCT acquisition path: capture FSM states
// and the default frame geometry also used by the host readout logic.
package oct_acq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CAPTURE   = 2'd1,
        FRAME_END = 2'd2
    } aline_state_t;

    localparam int OCT_DATA_W  = 16;
    localparam int OCT_SAMPLES = 1024;
    localparam int OCT_LINES   = 512;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable and synchronous reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count enabled increments, holding at all-ones once reached.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/aline_bank_ctrl.sv
// Ping-pong capture controller: writes each A-line's ADC samples into a
// two-bank frame RAM and swaps banks at frame end only when the host is
// not reading. Frames finishing while the host is busy are dropped.
module aline_bank_ctrl
    import oct_acq_pkg::*;
#(
    parameter int DATA_W  = OCT_DATA_W,
    parameter int SAMPLES = OCT_SAMPLES,
    parameter int LINES   = OCT_LINES,
    parameter int SW      = $clog2(SAMPLES),
    parameter int LW      = $clog2(LINES),
    parameter int DROP_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sweep_trig,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              read_busy,
    output logic              ram_we,
    output logic [LW+SW:0]    ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              rd_bank,
    output logic              frame_ready,
    output logic [DROP_W-1:0] drop_cnt
);

    aline_state_t  state;
    logic [SW-1:0] sample;
    logic [LW-1:0] line;
    logic          wr_bank;
    logic          busy_d;
    logic          drop_inc;

    // A frame is discarded when it completes while the host still holds its bank.
    assign drop_inc = (state == FRAME_END) && read_busy;

    sat_counter #(
        .W (DROP_W)
    ) u_drop_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (drop_inc),
        .count (drop_cnt)
    );

    // Capture FSM, registered RAM write port and bank handshake with the host.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sample      <= '0;
            line        <= '0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b1;
            frame_ready <= 1'b0;
            busy_d      <= 1'b1;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
        end else begin
            ram_we <= 1'b0;
            busy_d <= read_busy;

            if (read_busy && !busy_d) begin
                frame_ready <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (sweep_trig) begin
                        sample <= '0;
                        state  <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    if (adc_valid) begin
                        ram_we    <= 1'b1;
                        ram_addr  <= {wr_bank, line, sample};
                        ram_wdata <= adc_data;
                        if (sample == SW'(SAMPLES - 1)) begin
                            sample <= '0;
                            if (line != LW'(LINES - 1)) begin
                                line  <= line + LW'(1);
                                state <= IDLE;
                            end else begin
                                state <= FRAME_END;
                            end
                        end else begin
                            sample <= sample + SW'(1);
                        end
                    end
                end

                FRAME_END: begin
                    if (!read_busy) begin
                        wr_bank     <= ~wr_bank;
                        rd_bank     <= wr_bank;
                        frame_ready <= 1'b1;
                    end
                    line  <= '0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aline_bank_ctrl.sv
// Directed testbench for aline_bank_ctrl with SAMPLES=8, LINES=2.
module tb_aline_bank_ctrl;

    localparam int DATA_W  = 16;
    localparam int SAMPLES = 8;
    localparam int LINES   = 2;
    localparam int AW      = 5;

    logic              clk;
    logic              reset;
    logic              sweep_trig;
    logic              adc_valid;
    logic [DATA_W-1:0] adc_data;
    logic              read_busy;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              rd_bank;
    logic              frame_ready;
    logic [15:0]       drop_cnt;

    logic              ram_we2;
    logic [AW-1:0]     ram_addr2;
    logic [DATA_W-1:0] ram_wdata2;
    logic              rd_bank2;
    logic              frame_ready2;
    logic [1:0]        drop_cnt2;

    int checks   = 0;
    int failures = 0;

    int gaps [SAMPLES] = '{0, 2, 1, 3, 0, 1, 2, 0};

    aline_bank_ctrl #(
        .DATA_W  (DATA_W),
        .SAMPLES (SAMPLES),
        .LINES   (LINES),
        .DROP_W  (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sweep_trig  (sweep_trig),
        .adc_valid   (adc_valid),
        .adc_data    (adc_data),
        .read_busy   (read_busy),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .rd_bank     (rd_bank),
        .frame_ready (frame_ready),
        .drop_cnt    (drop_cnt)
    );

    aline_bank_ctrl #(
        .DATA_W  (DATA_W),
        .SAMPLES (SAMPLES),
        .LINES   (LINES),
        .DROP_W  (2)
    ) dut_sat (
        .clk         (clk),
        .reset       (reset),
        .sweep_trig  (sweep_trig),
        .adc_valid   (adc_valid),
        .adc_data    (adc_data),
        .read_busy   (read_busy),
        .ram_we      (ram_we2),
        .ram_addr    (ram_addr2),
        .ram_wdata   (ram_wdata2),
        .rd_bank     (rd_bank2),
        .frame_ready (frame_ready2),
        .drop_cnt    (drop_cnt2)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        sweep_trig = 1'b0;
        adc_valid  = 1'b0;
        adc_data   = '0;
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic pulse_trig();
        sweep_trig = 1'b1;
        step();
        sweep_trig = 1'b0;
    endtask

    // Capture one full A-line and check every write one cycle after its valid.
    task automatic do_line(input logic [AW-1:0] base, input logic [DATA_W-1:0] dbase,
                           input bit mid_trig);
        logic [AW-1:0]     exp_a;
        logic [DATA_W-1:0] exp_d;
        pulse_trig();
        for (int i = 0; i < SAMPLES; i++) begin
            exp_a      = base + AW'(i);
            exp_d      = dbase + DATA_W'(i);
            adc_valid  = 1'b1;
            adc_data   = exp_d;
            sweep_trig = mid_trig && (i == 3);
            step();
            adc_valid  = 1'b0;
            sweep_trig = 1'b0;
            checks++;
            if (ram_we !== 1'b1) begin
                failures++;
                $display("[TB] FAIL we_%0h: got %0b expected 1", exp_a, ram_we);
            end
            checks++;
            if (ram_addr !== exp_a) begin
                failures++;
                $display("[TB] FAIL addr_%0h: got %0h expected %0h", exp_a, ram_addr, exp_a);
            end
            checks++;
            if (ram_wdata !== exp_d) begin
                failures++;
                $display("[TB] FAIL data_%0h: got %0h expected %0h", exp_a, ram_wdata, exp_d);
            end
            for (int g = 0; g < gaps[i]; g++) begin
                step();
                checks++;
                if (ram_we !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL gap_we_%0h: got %0b expected 0", exp_a, ram_we);
                end
            end
        end
    endtask

    // Two lines then the FRAME_END cycle.
    task automatic do_frame(input logic bank, input logic [DATA_W-1:0] dbase);
        do_line({bank, 4'd0}, dbase, 1'b0);
        do_line({bank, 4'd8}, dbase + 16'd8, 1'b0);
        step();
    endtask

    task automatic test_reset();
        read_busy = 1'b1;
        reset     = 1'b1;
        sweep_trig = 1'b0;
        adc_valid = 1'b0;
        adc_data  = '0;
        repeat (2) step();
        checks++;
        if (rd_bank !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_rd_bank: got %0b expected 1", rd_bank);
        end
        checks++;
        if (frame_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_frame_ready: got %0b expected 0", frame_ready);
        end
        checks++;
        if (drop_cnt !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset_drop_cnt: got %0d expected 0", drop_cnt);
        end
        checks++;
        if (ram_we !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ram_we: got %0b expected 0", ram_we);
        end
        checks++;
        if (dut.busy_d !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_busy_d: got %0b expected 1", dut.busy_d);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_line();
        read_busy = 1'b1;
        do_reset();
        do_line(5'd0, 16'h0100, 1'b0);
        adc_valid = 1'b1;
        adc_data  = 16'h0BAD;
        step();
        adc_valid = 1'b0;
        checks++;
        if (ram_we !== 1'b0) begin
            failures++;
            $display("[TB] FAIL extra_valid_we: got %0b expected 0", ram_we);
        end
    endtask

    task automatic test_drop();
        read_busy = 1'b1;
        do_reset();
        do_frame(1'b0, 16'h0200);
        checks++;
        if (drop_cnt !== 16'd1) begin
            failures++;
            $display("[TB] FAIL drop_cnt_1: got %0d expected 1", drop_cnt);
        end
        checks++;
        if (rd_bank !== 1'b1) begin
            failures++;
            $display("[TB] FAIL drop_rd_bank: got %0b expected 1", rd_bank);
        end
        checks++;
        if (frame_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL drop_frame_ready: got %0b expected 0", frame_ready);
        end
        do_frame(1'b0, 16'h0300);
        checks++;
        if (drop_cnt !== 16'd2) begin
            failures++;
            $display("[TB] FAIL drop_cnt_2: got %0d expected 2", drop_cnt);
        end
    endtask

    task automatic test_swap_handshake();
        read_busy = 1'b1;
        do_reset();
        read_busy = 1'b0;
        step();
        do_frame(1'b0, 16'h0400);
        checks++;
        if (rd_bank !== 1'b0) begin
            failures++;
            $display("[TB] FAIL swap_rd_bank: got %0b expected 0", rd_bank);
        end
        checks++;
        if (frame_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL swap_frame_ready: got %0b expected 1", frame_ready);
        end
        read_busy = 1'b1;
        step();
        checks++;
        if (frame_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL claim_frame_ready: got %0b expected 0", frame_ready);
        end
        read_busy = 1'b0;
        step();
        do_line(5'd16, 16'h0500, 1'b1);
        do_line(5'd24, 16'h0508, 1'b0);
        step();
        checks++;
        if (rd_bank !== 1'b1) begin
            failures++;
            $display("[TB] FAIL swap2_rd_bank: got %0b expected 1", rd_bank);
        end
        checks++;
        if (frame_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL swap2_frame_ready: got %0b expected 1", frame_ready);
        end
        checks++;
        if (drop_cnt !== 16'd0) begin
            failures++;
            $display("[TB] FAIL swap_drop_cnt: got %0d expected 0", drop_cnt);
        end
    endtask

    task automatic test_corners();
        logic [1:0] exp_sat;
        read_busy = 1'b1;
        do_reset();
        do_line(5'd0, 16'h0600, 1'b0);
        pulse_trig();
        for (int i = 0; i < 4; i++) begin
            adc_valid = 1'b1;
            adc_data  = 16'h0700 + 16'(i);
            step();
        end
        adc_valid = 1'b0;
        do_reset();
        checks++;
        if (ram_we !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_we: got %0b expected 0", ram_we);
        end
        pulse_trig();
        adc_valid = 1'b1;
        adc_data  = 16'h0800;
        step();
        adc_valid = 1'b0;
        checks++;
        if (ram_addr !== 5'd0 || ram_we !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midreset_addr: got we=%0b addr=%0h expected we=1 addr=0",
                     ram_we, ram_addr);
        end

        do_reset();
        for (int f = 1; f <= 4; f++) begin
            do_frame(1'b0, 16'h0900);
            exp_sat = (f >= 3) ? 2'd3 : 2'(f);
            checks++;
            if (drop_cnt2 !== exp_sat) begin
                failures++;
                $display("[TB] FAIL sat_drop_%0d: got %0d expected %0d", f, drop_cnt2, exp_sat);
            end
        end
        checks++;
        if (drop_cnt !== 16'd4) begin
            failures++;
            $display("[TB] FAIL wide_drop: got %0d expected 4", drop_cnt);
        end
    endtask

    // Run all scenarios in order, then report.
    initial begin
        test_reset();
        test_single_line();
        test_drop();
        test_swap_handshake();
        test_corners();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
